// File: rtl/lab5_pkg.sv
// Shared constants, state types and small helpers for the lab5 shape-guessing game.
package lab5_pkg;

  localparam int unsigned SHAPE_W    = 3;
  localparam int unsigned PATTERN_W  = 12;
  localparam int unsigned COUNT_W    = 4;
  localparam int unsigned MAX_ROUNDS = 8;
  localparam int unsigned GAME_COST  = 4;
  localparam int unsigned MAX_GAMES  = 7;

  localparam logic [2:0] SHAPE_T = 3'b001;
  localparam logic [2:0] SHAPE_C = 3'b010;
  localparam logic [2:0] SHAPE_O = 3'b011;
  localparam logic [2:0] SHAPE_D = 3'b100;
  localparam logic [2:0] SHAPE_I = 3'b101;
  localparam logic [2:0] SHAPE_Z = 3'b110;

  localparam logic [1:0] COIN_NONE     = 2'b00;
  localparam logic [1:0] COIN_CIRCLE   = 2'b01;
  localparam logic [1:0] COIN_TRIANGLE = 2'b10;
  localparam logic [1:0] COIN_PENTAGON = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, GUESS, DONE} gameState_t;
  typedef enum logic [1:0] {C0, C1, C2, C3} creditState_t;

  // Credits granted by one coin of the given type.
  function automatic logic [3:0] coinCredits(input logic [1:0] coin);
    case (coin)
      COIN_CIRCLE:   return 4'd1;
      COIN_TRIANGLE: return 4'd3;
      COIN_PENTAGON: return 4'd5;
      default:       return 4'd0;
    endcase
  endfunction

  // True for the six legal shape codes.
  function automatic logic isValidShape(input logic [SHAPE_W-1:0] s);
    case (s)
      SHAPE_T, SHAPE_C, SHAPE_O, SHAPE_D, SHAPE_I, SHAPE_Z: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // True once every slot of a pattern holds a legal shape.
  function automatic logic patternComplete(input logic [PATTERN_W-1:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!isValidShape(p[SHAPE_W*i +: SHAPE_W])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/lab5_coin.sv
// Coin acceptor: accumulates credit and reports whole games bought per coin.
module myCoinFSM
  import lab5_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] CoinValue,
  input  logic       CoinInserted,
  output logic       drop,
  output logic [1:0] gamesAdded
);

  creditState_t state;
  creditState_t stateNext;
  logic         coinPrev;
  logic         dropNext;
  logic [1:0]   gamesNext;
  logic [3:0]   sum;

  // Credit register, coin edge detector and registered game pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= C0;
      coinPrev   <= 1'b0;
      drop       <= 1'b0;
      gamesAdded <= 2'd0;
    end else begin
      state      <= stateNext;
      coinPrev   <= CoinInserted;
      drop       <= dropNext;
      gamesAdded <= gamesNext;
    end
  end

  // On a fresh coin, convert credit into games four credits at a time.
  always_comb begin
    stateNext = state;
    dropNext  = 1'b0;
    gamesNext = 2'd0;
    sum       = 4'd0;
    if (CoinInserted && !coinPrev && CoinValue != COIN_NONE) begin
      sum = 4'(state) + coinCredits(CoinValue);
      if (sum >= 4'(2 * GAME_COST))
        gamesNext = 2'd2;
      else if (sum >= 4'(GAME_COST))
        gamesNext = 2'd1;
      stateNext = creditState_t'(2'(sum - 4'(GAME_COST) * 4'(gamesNext)));
      dropNext  = (gamesNext != 2'd0);
    end
  end

endmodule

// File: rtl/lab5.sv
// Top of the coin-operated shape-guessing game: game FSM, pattern store, grading.
// Optional feature macro LAB5_DEBUG_EN: debug input also reveals the master pattern.
module lab5
  import lab5_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           CoinValue,
  input  logic                 CoinInserted,
  input  logic                 StartGame,
  input  logic [PATTERN_W-1:0] Guess,
  input  logic                 GradeIt,
  input  logic [SHAPE_W-1:0]   LoadShape,
  input  logic [1:0]           ShapeLocation,
  input  logic                 LoadShapeNow,
  input  logic                 debug,
  output logic [COUNT_W-1:0]   Znarly,
  output logic [COUNT_W-1:0]   Zood,
  output logic [COUNT_W-1:0]   RoundNumber,
  output logic [COUNT_W-1:0]   NumGames,
  output logic                 GameWon,
  output logic                 loadNumGames,
  output logic                 loadGuess,
  output logic                 loadZnarlyZood,
  output logic                 clearGame,
  output logic                 displayMasterPattern,
  output logic [PATTERN_W-1:0] masterPatternOut
);

  logic                 coinDrop;
  logic [1:0]           coinGames;
  gameState_t           gameState;
  gameState_t           gameStateNext;
  logic                 startPrev;
  logic                 gradePrev;
  logic [PATTERN_W-1:0] masterPattern;
  logic [PATTERN_W-1:0] masterPatternNext;
  logic [COUNT_W-1:0]   znarlyNext;
  logic [COUNT_W-1:0]   zoodNext;
  logic [COUNT_W-1:0]   roundNext;
  logic [COUNT_W-1:0]   numGamesNext;
  logic                 gameWonNext;
  logic                 loadNumGamesNext;
  logic                 loadGuessNext;
  logic                 loadZnarlyZoodNext;
  logic                 clearGameNext;
  logic                 displayNext;
  logic [PATTERN_W-1:0] patternOutNext;
  logic                 startRise;
  logic                 gradeRise;
  logic                 startOk;
  logic                 showPattern;
  logic [4:0]           numSum;
  logic [COUNT_W-1:0]   gradeZnarly;
  logic [COUNT_W-1:0]   gradeZood;
  logic [COUNT_W-1:0]   gradeTotal;
  logic [COUNT_W-1:0]   cntMaster;
  logic [COUNT_W-1:0]   cntGuess;

  myCoinFSM mydesign (
    .clock        (clock),
    .reset        (reset),
    .CoinValue    (CoinValue),
    .CoinInserted (CoinInserted),
    .drop         (coinDrop),
    .gamesAdded   (coinGames)
  );

  assign startRise = StartGame && !startPrev;
  assign gradeRise = GradeIt && !gradePrev;

`ifdef LAB5_DEBUG_EN
  assign showPattern = displayNext || debug;
`else
  logic unusedDebug;
  assign unusedDebug = debug;
  assign showPattern = displayNext;
`endif

  // Grade the current guess: exact matches, then shape-count overlap minus exact matches.
  always_comb begin
    gradeZnarly = '0;
    gradeTotal  = '0;
    cntMaster   = '0;
    cntGuess    = '0;
    for (int i = 0; i < 4; i++) begin
      if (isValidShape(Guess[SHAPE_W*i +: SHAPE_W]) &&
          Guess[SHAPE_W*i +: SHAPE_W] == masterPattern[SHAPE_W*i +: SHAPE_W])
        gradeZnarly = gradeZnarly + 4'd1;
    end
    for (int code = 1; code <= 6; code++) begin
      cntMaster = '0;
      cntGuess  = '0;
      for (int i = 0; i < 4; i++) begin
        if (masterPattern[SHAPE_W*i +: SHAPE_W] == SHAPE_W'(code)) cntMaster = cntMaster + 4'd1;
        if (Guess[SHAPE_W*i +: SHAPE_W] == SHAPE_W'(code))         cntGuess  = cntGuess + 4'd1;
      end
      gradeTotal = gradeTotal + ((cntMaster < cntGuess) ? cntMaster : cntGuess);
    end
    gradeZood = gradeTotal - gradeZnarly;
  end

  // All game registers, including registered strobes and display values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gameState            <= IDLE;
      startPrev            <= 1'b0;
      gradePrev            <= 1'b0;
      masterPattern        <= '0;
      Znarly               <= '0;
      Zood                 <= '0;
      RoundNumber          <= '0;
      NumGames             <= '0;
      GameWon              <= 1'b0;
      loadNumGames         <= 1'b0;
      loadGuess            <= 1'b0;
      loadZnarlyZood       <= 1'b0;
      clearGame            <= 1'b0;
      displayMasterPattern <= 1'b0;
      masterPatternOut     <= '0;
    end else begin
      gameState            <= gameStateNext;
      startPrev            <= StartGame;
      gradePrev            <= GradeIt;
      masterPattern        <= masterPatternNext;
      Znarly               <= znarlyNext;
      Zood                 <= zoodNext;
      RoundNumber          <= roundNext;
      NumGames             <= numGamesNext;
      GameWon              <= gameWonNext;
      loadNumGames         <= loadNumGamesNext;
      loadGuess            <= loadGuessNext;
      loadZnarlyZood       <= loadZnarlyZoodNext;
      clearGame            <= clearGameNext;
      displayMasterPattern <= displayNext;
      masterPatternOut     <= patternOutNext;
    end
  end

  // Next-state and next-output logic for the game FSM and game counter.
  always_comb begin
    gameStateNext      = gameState;
    masterPatternNext  = masterPattern;
    znarlyNext         = Znarly;
    zoodNext           = Zood;
    roundNext          = RoundNumber;
    gameWonNext        = GameWon;
    loadGuessNext      = 1'b0;
    loadZnarlyZoodNext = 1'b0;
    clearGameNext      = 1'b0;

    startOk = startRise && (gameState == IDLE || gameState == DONE) && (NumGames != '0);

    // Paid games arrive one cycle after the coin pulse; a start consumes one.
    numSum = 5'(NumGames) + (coinDrop ? 5'(coinGames) : 5'd0) - (startOk ? 5'd1 : 5'd0);
    numGamesNext     = (numSum > 5'(MAX_GAMES)) ? 4'(MAX_GAMES) : numSum[3:0];
    loadNumGamesNext = coinDrop || startOk;

    case (gameState)
      IDLE, DONE: begin
        if (startOk) begin
          gameStateNext     = LOAD;
          masterPatternNext = '0;
          znarlyNext        = '0;
          zoodNext          = '0;
          roundNext         = '0;
          gameWonNext       = 1'b0;
          clearGameNext     = 1'b1;
        end
      end
      LOAD: begin
        if (LoadShapeNow && isValidShape(LoadShape)) begin
          for (int i = 0; i < 4; i++) begin
            if (ShapeLocation == 2'(i)) masterPatternNext[SHAPE_W*i +: SHAPE_W] = LoadShape;
          end
        end
        if (patternComplete(masterPatternNext)) gameStateNext = GUESS;
      end
      GUESS: begin
        if (gradeRise) begin
          znarlyNext         = gradeZnarly;
          zoodNext           = gradeZood;
          roundNext          = RoundNumber + 4'd1;
          loadGuessNext      = 1'b1;
          loadZnarlyZoodNext = 1'b1;
          if (gradeZnarly == 4'd4) begin
            gameWonNext   = 1'b1;
            gameStateNext = DONE;
          end else if (roundNext == 4'(MAX_ROUNDS)) begin
            gameStateNext = DONE;
          end
        end
      end
      default: gameStateNext = IDLE;
    endcase

    displayNext    = (gameStateNext == DONE);
    patternOutNext = showPattern ? masterPatternNext : '0;
  end

endmodule

// File: tb/tb_lab5.sv
// Self-checking bench for lab5: directed scenarios plus randomized play against a game model.
module tb_lab5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  CoinValue = 2'b00;
  logic        CoinInserted = 1'b0;
  logic        StartGame = 1'b0;
  logic [11:0] Guess = 12'd0;
  logic        GradeIt = 1'b0;
  logic [2:0]  LoadShape = 3'd0;
  logic [1:0]  ShapeLocation = 2'd0;
  logic        LoadShapeNow = 1'b0;
  logic        debug = 1'b0;
  logic [3:0]  Znarly, Zood, RoundNumber, NumGames;
  logic        GameWon, loadNumGames, loadGuess, loadZnarlyZood, clearGame, displayMasterPattern;
  logic [11:0] masterPatternOut;

  lab5 dut (
    .clock(clock), .reset(reset), .CoinValue(CoinValue), .CoinInserted(CoinInserted),
    .StartGame(StartGame), .Guess(Guess), .GradeIt(GradeIt), .LoadShape(LoadShape),
    .ShapeLocation(ShapeLocation), .LoadShapeNow(LoadShapeNow), .debug(debug),
    .Znarly(Znarly), .Zood(Zood), .RoundNumber(RoundNumber), .NumGames(NumGames),
    .GameWon(GameWon), .loadNumGames(loadNumGames), .loadGuess(loadGuess),
    .loadZnarlyZood(loadZnarlyZood), .clearGame(clearGame),
    .displayMasterPattern(displayMasterPattern), .masterPatternOut(masterPatternOut)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nPass = 0;
  int dropSeen = 0;
  int loadNumSeen = 0;
  int clearSeen = 0;

  // Game model: credit, pending games, counters, pattern and strobes.
  int mCredit, mGames, mNumGames, mState, mZnarly, mZood, mRound, mPatOut;
  int mPat[4];
  bit mDrop, mWon, mLoadNum, mLoadGuess, mLoadZZ, mClear, mDisplay;
  bit mCoinPrev, mStartPrev, mGradePrev;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int coinVal(input logic [1:0] v);
    case (v)
      2'b01: return 1;
      2'b10: return 3;
      2'b11: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int packPat();
    return mPat[0] + (mPat[1] << 3) + (mPat[2] << 6) + (mPat[3] << 9);
  endfunction

  // Mastermind score: exact hits, then per-shape overlap minus exact hits.
  function automatic void grade(input int m[4], input int g[4], output int zn, output int zo);
    int cm, cg, total;
    zn = 0;
    total = 0;
    for (int i = 0; i < 4; i++) if (m[i] == g[i] && m[i] >= 1 && m[i] <= 6) zn++;
    for (int c = 1; c <= 6; c++) begin
      cm = 0;
      cg = 0;
      for (int i = 0; i < 4; i++) begin
        if (m[i] == c) cm++;
        if (g[i] == c) cg++;
      end
      total += (cm < cg) ? cm : cg;
    end
    zo = total - zn;
  endfunction

  function automatic void modelReset();
    mCredit = 0; mGames = 0; mNumGames = 0; mState = 0; mZnarly = 0; mZood = 0; mRound = 0;
    mPatOut = 0; mDrop = 0; mWon = 0; mLoadNum = 0; mLoadGuess = 0; mLoadZZ = 0; mClear = 0;
    mDisplay = 0; mCoinPrev = 0; mStartPrev = 0; mGradePrev = 0;
    for (int i = 0; i < 4; i++) mPat[i] = 0;
  endfunction

  function automatic void modelStep();
    int sum, n, oldNum, oldState, oldGames, zn, zo;
    int gg[4];
    bit oldDrop, startOk, full, dbg;
    oldDrop = mDrop; oldGames = mGames; oldNum = mNumGames; oldState = mState;
    mDrop = 0; mGames = 0;
    if (CoinInserted && !mCoinPrev && CoinValue != 2'b00) begin
      sum = mCredit + coinVal(CoinValue);
      mGames = sum / 4;
      mCredit = sum % 4;
      mDrop = (mGames > 0);
    end
    startOk = StartGame && !mStartPrev && (oldState == 0 || oldState == 3) && oldNum > 0;
    n = oldNum + (oldDrop ? oldGames : 0) - (startOk ? 1 : 0);
    mNumGames = (n > 7) ? 7 : n;
    mLoadNum = oldDrop || startOk;
    mLoadGuess = 0; mLoadZZ = 0; mClear = 0;
    case (oldState)
      0, 3: if (startOk) begin
        mState = 1; mZnarly = 0; mZood = 0; mRound = 0; mWon = 0; mClear = 1;
        for (int i = 0; i < 4; i++) mPat[i] = 0;
      end
      1: begin
        if (LoadShapeNow && LoadShape != 3'd0 && LoadShape != 3'd7) mPat[ShapeLocation] = int'(LoadShape);
        full = 1;
        for (int i = 0; i < 4; i++) if (mPat[i] < 1 || mPat[i] > 6) full = 0;
        if (full) mState = 2;
      end
      2: if (GradeIt && !mGradePrev) begin
        for (int i = 0; i < 4; i++) gg[i] = int'(Guess[3*i +: 3]);
        grade(mPat, gg, zn, zo);
        mZnarly = zn; mZood = zo; mRound++; mLoadGuess = 1; mLoadZZ = 1;
        if (zn == 4) begin mWon = 1; mState = 3; end
        else if (mRound == 8) mState = 3;
      end
      default: ;
    endcase
    mCoinPrev = CoinInserted; mStartPrev = StartGame; mGradePrev = GradeIt;
    mDisplay = (mState == 3);
`ifdef LAB5_DEBUG_EN
    dbg = debug;
`else
    dbg = 0;
`endif
    mPatOut = (mDisplay || dbg) ? packPat() : 0;
  endfunction

  // Advance the model at every edge and compare every output shortly after.
  always @(posedge clock) begin
    if (reset) modelReset();
    else modelStep();
    #1;
    if (!reset) begin
      check("credit", int'(dut.mydesign.state), mCredit);
      check("drop", int'(dut.mydesign.drop), int'(mDrop));
      check("gameState", int'(dut.gameState), mState);
      check("NumGames", int'(NumGames), mNumGames);
      check("Znarly", int'(Znarly), mZnarly);
      check("Zood", int'(Zood), mZood);
      check("RoundNumber", int'(RoundNumber), mRound);
      check("GameWon", int'(GameWon), int'(mWon));
      check("loadNumGames", int'(loadNumGames), int'(mLoadNum));
      check("loadGuess", int'(loadGuess), int'(mLoadGuess));
      check("loadZnarlyZood", int'(loadZnarlyZood), int'(mLoadZZ));
      check("clearGame", int'(clearGame), int'(mClear));
      check("displayMasterPattern", int'(displayMasterPattern), int'(mDisplay));
      check("masterPatternOut", int'(masterPatternOut), mPatOut);
      if (dut.mydesign.drop) dropSeen++;
      if (loadNumGames) loadNumSeen++;
      if (clearGame) clearSeen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic insertCoin(input logic [1:0] v);
    CoinInserted = 1'b0; tick(1);
    CoinValue = v; CoinInserted = 1'b1; tick(3);
    CoinInserted = 1'b0;
  endtask

  task automatic pulseStart();
    StartGame = 1'b1; tick(1);
    StartGame = 1'b0; tick(1);
  endtask

  task automatic loadSlot(input int loc, input logic [2:0] code);
    ShapeLocation = 2'(loc); LoadShape = code; LoadShapeNow = 1'b1; tick(1);
    LoadShapeNow = 1'b0; tick(1);
  endtask

  task automatic loadPattern(input logic [11:0] p);
    for (int i = 3; i >= 0; i--) loadSlot(i, p[3*i +: 3]);
  endtask

  task automatic gradeGuess(input logic [11:0] g);
    Guess = g; GradeIt = 1'b1; tick(1);
    GradeIt = 1'b0; tick(1);
  endtask

  localparam logic [11:0] IZDT = 12'b101_110_100_001;
  localparam logic [11:0] OODD = 12'b011_011_100_100;
  localparam logic [11:0] IOTZ = 12'b101_011_001_110;
  localparam logic [11:0] TIZD = 12'b001_101_110_100;
  localparam logic [11:0] TCOD = 12'b001_010_011_100;

  initial begin
    int m[4], g[4], zn, zo;
    logic [11:0] pat, gs;
    modelReset();

    // Pin the scoring model with hand-computed results.
    pat = IZDT;
    for (int i = 0; i < 4; i++) m[i] = int'(pat[3*i +: 3]);
    gs = OODD; for (int i = 0; i < 4; i++) g[i] = int'(gs[3*i +: 3]);
    grade(m, g, zn, zo); check("model OODD znarly", zn, 1); check("model OODD zood", zo, 0);
    gs = IOTZ; for (int i = 0; i < 4; i++) g[i] = int'(gs[3*i +: 3]);
    grade(m, g, zn, zo); check("model IOTZ znarly", zn, 1); check("model IOTZ zood", zo, 2);
    gs = TIZD; for (int i = 0; i < 4; i++) g[i] = int'(gs[3*i +: 3]);
    grade(m, g, zn, zo); check("model TIZD znarly", zn, 0); check("model TIZD zood", zo, 4);

    tick(2);
    reset = 1'b0;
    tick(1);
    check("reset NumGames", int'(NumGames), 0);
    check("reset state", int'(dut.gameState), 0);
    check("reset pattern out", int'(masterPatternOut), 0);

    // Triangle held high: credited once only.
    dropSeen = 0;
    CoinValue = 2'b10; CoinInserted = 1'b1; tick(9);
    check("held coin credit", int'(dut.mydesign.state), 3);
    check("held coin drops", dropSeen, 0);
    check("held coin NumGames", int'(NumGames), 0);

    // Second triangle completes one game.
    dropSeen = 0; loadNumSeen = 0;
    insertCoin(2'b10);
    check("triangle credit", int'(dut.mydesign.state), 2);
    check("triangle drops", dropSeen, 1);
    check("triangle NumGames", int'(NumGames), 1);
    check("triangle loadNumGames", loadNumSeen, 1);

    // C3 plus pentagon buys two games.
    insertCoin(2'b01);
    check("circle credit", int'(dut.mydesign.state), 3);
    insertCoin(2'b11);
    check("pentagon credit", int'(dut.mydesign.state), 0);
    check("pentagon NumGames", int'(NumGames), 3);

    // Game 1: load IZDT with an invalid write and a rewrite, then grade.
    clearSeen = 0;
    pulseStart();
    check("start state", int'(dut.gameState), 1);
    check("start NumGames", int'(NumGames), 2);
    check("start clearGame", clearSeen, 1);
    loadSlot(3, 3'b111);
    loadSlot(2, 3'b001);
    loadPattern(IZDT);
    check("loaded state", int'(dut.gameState), 2);
    gradeGuess(OODD); check("OODD znarly", int'(Znarly), 1); check("OODD zood", int'(Zood), 0);
    gradeGuess(IOTZ); check("IOTZ znarly", int'(Znarly), 1); check("IOTZ zood", int'(Zood), 2);
    gradeGuess(TIZD); check("TIZD znarly", int'(Znarly), 0); check("TIZD zood", int'(Zood), 4);
    gradeGuess(IZDT);
    check("win znarly", int'(Znarly), 4);
    check("win GameWon", int'(GameWon), 1);
    check("win state", int'(dut.gameState), 3);
    check("win pattern out", int'(masterPatternOut), int'(IZDT));

    // Game 2: eight losing guesses; debug peek during load.
    pulseStart();
    loadSlot(3, 3'b101);
    loadSlot(2, 3'b110);
    debug = 1'b1; tick(1);
`ifdef LAB5_DEBUG_EN
    check("debug partial pattern", int'(masterPatternOut), int'(12'b101_110_000_000));
`else
    check("debug ignored", int'(masterPatternOut), 0);
`endif
    debug = 1'b0;
    loadSlot(1, 3'b100);
    loadSlot(0, 3'b001);
    for (int r = 0; r < 8; r++) begin
      gs = 12'($urandom);
      if (gs == IZDT) gs = OODD;
      gradeGuess(gs);
    end
    check("lose RoundNumber", int'(RoundNumber), 8);
    check("lose GameWon", int'(GameWon), 0);
    check("lose display", int'(displayMasterPattern), 1);

    // Game 3: last paid game, win at once, then start with nothing left.
    pulseStart();
    loadPattern(TCOD);
    gradeGuess(TCOD);
    check("game3 NumGames", int'(NumGames), 0);
    pulseStart();
    check("no-credit start state", int'(dut.gameState), 3);

    // Reset in the middle of a game.
    insertCoin(2'b11);
    pulseStart();
    loadPattern(TCOD);
    gradeGuess(OODD);
    check("pre-reset state", int'(dut.gameState), 2);
    reset = 1'b1; #1;
    check("async reset state", int'(dut.gameState), 0);
    check("async reset RoundNumber", int'(RoundNumber), 0);
    check("async reset Znarly", int'(Znarly), 0);
    check("async reset credit", int'(dut.mydesign.state), 0);
    tick(2);
    reset = 1'b0;

    // Randomized play checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1; tick(2); reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) CoinInserted = ~CoinInserted;
      CoinValue = 2'($urandom);
      if ($urandom_range(0, 5) == 0) StartGame = ~StartGame;
      if ($urandom_range(0, 2) == 0) GradeIt = ~GradeIt;
      LoadShapeNow = ($urandom_range(0, 2) == 0);
      LoadShape = 3'($urandom);
      ShapeLocation = 2'($urandom);
      Guess = ($urandom_range(0, 3) == 0) ? 12'(packPat()) : 12'($urandom);
      debug = ($urandom_range(0, 7) == 0);
    end
    tick(2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/lab5.md
# lab5

Top level of the coin-operated shape-guessing game (Mastermind style). It accepts coins to buy games, loads a secret four-shape master pattern, and grades up to eight guesses per game with Znarly/Zood counts. It also produces the strobes and values that drive the external display logic.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns every register to its reset value.
- CoinValue  in  2  coin type: 00 none, 01 circle = 1 credit, 10 triangle = 3, 11 pentagon = 5.
- CoinInserted  in  1  level; a coin is counted once per rising edge of this signal.
- StartGame  in  1  level; acted on at its rising edge.
- Guess  in  12  four 3-bit shapes; location 3 = [11:9] … location 0 = [2:0].
- GradeIt  in  1  level; acted on at its rising edge.
- LoadShape  in  3  shape code: T=001, C=010, O=011, D=100, I=101, Z=110; codes 000 and 111 are invalid.
- ShapeLocation  in  2  target slot for LoadShape.
- LoadShapeNow  in  1  write strobe for the master pattern.
- debug  in  1  forces display of the master pattern.
- Znarly, Zood  out  4  last grading result.
- RoundNumber  out  4  guesses graded in the current game, 0–8.
- NumGames  out  4  games paid for and not yet started, saturates at 7.
- GameWon  out  1  set by a guess with Znarly = 4.
- loadNumGames, loadGuess, loadZnarlyZood, clearGame  out  1  one-cycle display strobes.
- displayMasterPattern  out  1  high in DONE.
- masterPatternOut  out  12  master pattern when displayed, otherwise 0.

## Operation
- Coin acceptor:
  - credit state: C0..C3.
  - On a CoinInserted rising edge with CoinValue ≠ 00, compute sum = credit + value.
  - games = sum≥8 ? 2 : sum≥4 ? 1 : 0; new credit = sum − 4·games.
  - `drop` is high for that one cycle when games > 0.
  - NumGames += games, saturating at 7. The credit is still consumed when NumGames saturates.
- Game FSM states IDLE, LOAD, GUESS, DONE.
  - IDLE/DONE → LOAD: on a StartGame rising edge with NumGames > 0.
    - NumGames decrements.
    - Master pattern, Znarly, Zood, RoundNumber and GameWon are cleared.
    - clearGame and loadNumGames pulse.
  - StartGame with NumGames = 0 is ignored.
  - LOAD: LoadShapeNow writes LoadShape into slot ShapeLocation. Invalid codes are not written, and rewriting a slot is allowed.
  - LOAD → GUESS: when all four slots hold valid codes.
  - GUESS: on a GradeIt rising edge, grade Guess against the master pattern.
    - Znarly = number of positions with equal valid codes.
    - Zood = Σ over codes 1..6 of min(count in master, count in guess), minus Znarly.
    - RoundNumber increments; loadGuess and loadZnarlyZood pulse.
  - GUESS → DONE: when Znarly = 4 (GameWon ← 1), or when RoundNumber reaches 8.
- DONE:
  - displayMasterPattern = 1.
  - Outputs hold.
  - A coin may be inserted in any state.

## Timing
- Reset value of all outputs, credit, the edge-detect registers and the pattern is 0; the FSM resets to IDLE.
- Edge detection compares each input to its value registered on the previous cycle.
  - A rise sampled at edge k acts at edge k.
  - Holding the input high has no further effect.
- Coin acceptor:
  - `drop` and credit update at edge k.
  - NumGames updates at edge k+1, with loadNumGames high in the cycle after it.
- Grading:
  - Znarly, Zood, RoundNumber and GameWon are registered at the GradeIt edge.
  - loadZnarlyZood is high during the following cycle.
- Simultaneous drop and game start in one cycle: both take effect; net NumGames change = games − 1.
- Reset mid-game discards the game, the credit and NumGames.

## Configuration
- LAB5_DEBUG_EN:
  - Defined: masterPatternOut = master pattern when debug or displayMasterPattern is high.
  - Undefined: the debug input is ignored; the pattern is output only when displayMasterPattern is high.

## Structure
- Package lab5_pkg holds:
  - shape-code constants;
  - the coin-value constants;
  - the game-state and credit-state enums;
  - MAX_ROUNDS = 8, GAME_COST = 4, MAX_GAMES = 7.
- Sub-module myCoinFSM implements the coin acceptor, instantiated as `mydesign`.
  - Its credit register is named `state` and its pulse `drop`; benches probe these hierarchically.
- Grading is combinational logic inside lab5.

## Test plan
- Reset, CoinValue=10, CoinInserted held high 9 cycles → credit C3 after one edge, no drop, NumGames 0.
- Triangle, release, triangle → drop once, credit C2, NumGames 1, one loadNumGames pulse.
- Credit C3 plus pentagon → two games, credit C0, NumGames +2.
- Load master IZDT (101110100001), then grade each guess:
  - OODD → Znarly 1, Zood 0;
  - IOTZ → Znarly 1, Zood 2;
  - TIZD → Znarly 0, Zood 4;
  - IZDT → Znarly 4, GameWon 1, state DONE.
- Eight non-winning guesses → RoundNumber 8, GameWon 0, displayMasterPattern 1; StartGame with NumGames 0 stays in DONE.
- Assert reset during GUESS → all outputs 0, state IDLE. With LAB5_DEBUG_EN, debug=1 in LOAD shows the partial pattern on masterPatternOut.
